// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Every output comes straight from a flop, so program memory sees a clean, registered address.
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h00400000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_i,
  input  logic                  Flush_i,
  input  logic                  PC_Src_i,
  input  logic [DATA_WIDTH-1:0] Target_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] IFID_PC_o,
  output logic [DATA_WIDTH-1:0] IFID_PC_Plus4_o,
  output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
  output logic                  IFID_Valid_o,
  output logic [31:0]           Fetch_Count_o
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [DATA_WIDTH-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic [31:0]           fetch_count_q, fetch_count_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  bubble;

  // Unsigned addition wraps naturally at 2^DATA_WIDTH.
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);
  assign bubble   = Flush_i | PC_Src_i;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block can infer a latch.
    pc_d            = pc_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_count_d   = fetch_count_q;

    // A redirect wins over a stall; the target is forced word-aligned.
    if (PC_Src_i) begin
      pc_d = {Target_i[DATA_WIDTH-1:2], 2'b00};
    end else if (!Stall_i) begin
      pc_d = pc_plus4;
    end

    if (bubble) begin
      ifid_pc_d       = '0;
      ifid_pc_plus4_d = '0;
      ifid_instr_d    = NOP_INSTR;
      ifid_valid_d    = 1'b0;
    end else if (!Stall_i) begin
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4;
      ifid_instr_d    = Instruction_i;
      ifid_valid_d    = 1'b1;
      fetch_count_d   = fetch_count_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= '0;
    end else begin
      pc_q            <= pc_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign PC_o               = pc_q;
  assign IFID_PC_o          = ifid_pc_q;
  assign IFID_PC_Plus4_o    = ifid_pc_plus4_q;
  assign IFID_Instruction_o = ifid_instr_q;
  assign IFID_Valid_o       = ifid_valid_q;
  assign Fetch_Count_o      = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a vector table feeds a scoreboard queue,
// followed by hand-written reset-release and asynchronous-reset sequences.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        stall_i, flush_i, pc_src_i;
  logic [31:0] target_i, instr_i;
  logic [31:0] pc_o, ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o, fetch_count_o;
  logic        ifid_valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        src;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_p4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];

  instruction_fetch dut (
    .clk                (clk),
    .reset              (reset),
    .Stall_i            (stall_i),
    .Flush_i            (flush_i),
    .PC_Src_i           (pc_src_i),
    .Target_i           (target_i),
    .Instruction_i      (instr_i),
    .PC_o               (pc_o),
    .IFID_PC_o          (ifid_pc_o),
    .IFID_PC_Plus4_o    (ifid_pc_plus4_o),
    .IFID_Instruction_o (ifid_instr_o),
    .IFID_Valid_o       (ifid_valid_o),
    .Fetch_Count_o      (fetch_count_o)
  );

  // Program memory: the word at 0x00400000 + 4*i holds i+1.
  assign instr_i = ((pc_o - 32'h00400000) >> 2) + 32'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, " pc"},      pc_o,            e.pc);
    check({tag, " ifid_pc"}, ifid_pc_o,       e.ifid_pc);
    check({tag, " ifid_p4"}, ifid_pc_plus4_o, e.ifid_p4);
    check({tag, " instr"},   ifid_instr_o,    e.instr);
    check({tag, " valid"},   32'(ifid_valid_o), 32'(e.valid));
    check({tag, " count"},   fetch_count_o,   e.cnt);
  endtask

  initial begin
    vec_t e;
    //          stall flush src   target         pc             ifid_pc        ifid_p4        instr          valid cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400004, 32'h00400000, 32'h00400004, 32'h1,        1'b1, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h00400004, 32'h00400008, 32'h2,        1'b1, 32'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h00400004, 32'h00400008, 32'h2,        1'b1, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h00400004, 32'h00400008, 32'h2,        1'b1, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0040000C, 32'h00400008, 32'h0040000C, 32'h3,        1'b1, 32'd3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400010, 32'h0040000C, 32'h00400010, 32'h4,        1'b1, 32'd4};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h00400014, 32'h0,        32'h0,        32'h13,       1'b0, 32'd4};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400018, 32'h00400014, 32'h00400018, 32'h6,        1'b1, 32'd5};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h00400023, 32'h00400020, 32'h0,        32'h0,        32'h13,       1'b0, 32'd5};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400024, 32'h00400020, 32'h00400024, 32'h9,        1'b1, 32'd6};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h00400024, 32'h0,        32'h0,        32'h13,       1'b0, 32'd6};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400028, 32'h00400024, 32'h00400028, 32'hA,        1'b1, 32'd7};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h13,       1'b0, 32'd7};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00000000, 32'hFFFFFFFC, 32'h00000000, 32'h3FF00000, 1'b1, 32'd8};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00000004, 32'h00000000, 32'h00000004, 32'h3FF00001, 1'b1, 32'd9};

    reset    = 1'b1;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    pc_src_i = 1'b0;
    target_i = '0;
    #1;
    check_all("reset", '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400000, 32'h0, 32'h0, 32'h13, 1'b0, 32'd0});

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      stall_i  = vecs[i].stall;
      flush_i  = vecs[i].flush;
      pc_src_i = vecs[i].src;
      target_i = vecs[i].target;
      sb.push_back(vecs[i]);
      @(negedge clk);
      if (sb.size() == 0) begin
        check("scoreboard empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check_all($sformatf("vec%0d", i), e);
      end
    end
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    pc_src_i = 1'b0;

    // Stall in progress, then reset asserted between edges must act immediately.
    stall_i = 1'b1;
    @(posedge clk);
    #2;
    check("stall before reset pc", pc_o, 32'h00000004);
    reset = 1'b1;
    #1;
    check("async reset pc",    pc_o,               32'h00400000);
    check("async reset valid", 32'(ifid_valid_o),  32'd0);
    check("async reset count", fetch_count_o,      32'd0);
    check("async reset instr", ifid_instr_o,       32'h13);

    // Release with the stall withdrawn: first edge fetches from RESET_PC.
    @(negedge clk);
    reset   = 1'b0;
    stall_i = 1'b0;
    @(negedge clk);
    check_all("post reset", '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00400004, 32'h00400000, 32'h00400004, 32'h1, 1'b1, 32'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
